// File: rtl/edge_pulse_gen.sv
// Programmable pulse-train generator: N pulses of H high / L low cycles, with abort and done strobe.
// Define EDGE_PULSE_GEN_MARK_EN to generate the wave_rise/wave_fall edge strobes.
module edge_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] pulse_num,
  output logic             wave_out,
  output logic             busy,
  output logic             done,
  output logic             wave_rise,
  output logic             wave_fall
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] phase_cnt, h_lim, l_lim;
  logic [NUM_W-1:0] pulse_cnt, pulse_inc, n_lat;
  logic             accept, phase_end;
  logic             wave_d, busy_d, done_d;

  assign accept    = (state == IDLE) && start && !stop;
  assign pulse_inc = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + NUM_W'(1);

  always_comb begin
    phase_end = 1'b0;
    case (state)
      HIGH:    phase_end = (phase_cnt == h_lim);
      LOW:     phase_end = (phase_cnt == l_lim);
      default: phase_end = 1'b0;
    endcase
  end

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      wave_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      wave_out <= wave_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (pulse_num == '0) ? FIN : HIGH;
      HIGH: begin
        if (stop)           state_next = FIN;
        else if (phase_end) state_next = LOW;
      end
      LOW: begin
        if (stop)           state_next = FIN;
        else if (phase_end) state_next = (pulse_inc < n_lat) ? HIGH : FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wave_d = (state_next == HIGH);
    busy_d = (state_next inside {HIGH, LOW});
    done_d = (state_next == FIN);
  end

  // Zero lengths behave as one cycle; stored as terminal count (length - 1)
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_lim <= '0;
      l_lim <= '0;
      n_lat <= '0;
    end else if (accept) begin
      h_lim <= (high_len == '0) ? '0 : high_len - CNT_W'(1);
      l_lim <= (low_len == '0) ? '0 : low_len - CNT_W'(1);
      n_lat <= pulse_num;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      phase_cnt <= '0;
      pulse_cnt <= '0;
    end else begin
      if (state_next != state)
        phase_cnt <= '0;
      else if ((state inside {HIGH, LOW}) && (phase_cnt != '1))
        phase_cnt <= phase_cnt + CNT_W'(1);

      if (state == IDLE)
        pulse_cnt <= '0;
      else if ((state == LOW) && phase_end && !stop)
        pulse_cnt <= pulse_inc;
    end
  end

`ifdef EDGE_PULSE_GEN_MARK_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wave_rise <= 1'b0;
      wave_fall <= 1'b0;
    end else begin
      wave_rise <= (state_next == HIGH) && (state != HIGH);
      wave_fall <= (state == HIGH) && (state_next != HIGH);
    end
  end
`else
  assign wave_rise = 1'b0;
  assign wave_fall = 1'b0;
`endif

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: fixed scenarios plus randomized trains against a timeline model.
module tb_edge_pulse_gen;
  localparam int CW = 4;
  localparam int NW = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst, start, stop;
  logic [CW-1:0] high_len, low_len;
  logic [NW-1:0] pulse_num;
  logic          wave_out, busy, done, wave_rise, wave_fall;
  logic [4:0]    act_v, exp_v;

  int   total = 0;
  int   bad   = 0;
  int   m_mode, m_k, m_h, m_l, m_n;
  logic m_prev;

  edge_pulse_gen #(.CNT_W(CW), .NUM_W(NW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .high_len(high_len), .low_len(low_len), .pulse_num(pulse_num),
    .wave_out(wave_out), .busy(busy), .done(done),
    .wave_rise(wave_rise), .wave_fall(wave_fall)
  );

  assign act_v = {wave_out, busy, done, wave_rise, wave_fall};

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_prev = 1'b0; exp_v = '0;
  endtask

  // Advance one clock; model is a timeline: cycle k of a train sits at offset (k-1) mod (H+L)
  task automatic advance();
    logic w, r, f;
    @(posedge sys_clk);
    case (m_mode)
      0: if (start && !stop) begin
        if (pulse_num == 0) m_mode = 2;
        else begin
          m_mode = 1; m_k = 1;
          m_h = (high_len == 0) ? 1 : int'(high_len);
          m_l = (low_len == 0) ? 1 : int'(low_len);
          m_n = int'(pulse_num);
        end
      end
      1: if (stop || m_k == m_n * (m_h + m_l)) m_mode = 2; else m_k++;
      default: m_mode = 0;
    endcase
    w = (m_mode == 1) && (((m_k - 1) % (m_h + m_l)) < m_h);
`ifdef EDGE_PULSE_GEN_MARK_EN
    r = w && !m_prev;
    f = !w && m_prev;
`else
    r = 1'b0;
    f = 1'b0;
`endif
    m_prev = w;
    exp_v = {w, m_mode == 1, m_mode == 2, r, f};
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 0; stop = 0; high_len = 0; low_len = 0; pulse_num = 0;
    model_reset();
    @(posedge sys_clk); #1;
    total++;
    if (act_v !== 5'b0) begin bad++; $display("FAIL reset got=%b exp=%b", act_v, 5'b0); end
    sys_rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      advance();
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL reset_idle got=%b exp=%b", act_v, exp_v); end
    end
  endtask

  task automatic test_basic();
    logic ew;
    high_len = 3; low_len = 2; pulse_num = 2; start = 1;
    for (int c = 1; c <= 13; c++) begin
      advance(); start = 0;
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL basic c=%0d got=%b exp=%b", c, act_v, exp_v); end
      ew = (c >= 1 && c <= 3) || (c >= 6 && c <= 8);
      total++;
      if ({wave_out, busy, done} !== {ew, c >= 1 && c <= 10, c == 11}) begin
        bad++; $display("FAIL basic_tl c=%0d got=%b exp=%b", c, {wave_out, busy, done}, {ew, c >= 1 && c <= 10, c == 11});
      end
    end
  endtask

  task automatic test_zero_pulses();
    high_len = 4; low_len = 4; pulse_num = 0; start = 1;
    for (int c = 1; c <= 3; c++) begin
      advance(); start = 0;
      total++;
      if ({wave_out, busy, done} !== {1'b0, 1'b0, c == 1}) begin
        bad++; $display("FAIL zero_pulses c=%0d got=%b exp=%b", c, {wave_out, busy, done}, {2'b00, c == 1});
      end
    end
  endtask

  task automatic test_zero_lengths();
    high_len = 0; low_len = 0; pulse_num = 3; start = 1;
    for (int c = 1; c <= 9; c++) begin
      advance(); start = 0;
      total++;
      if ({wave_out, done} !== {c <= 6 && (c % 2 == 1), c == 7} || act_v !== exp_v) begin
        bad++; $display("FAIL zero_len c=%0d got=%b exp=%b", c, act_v, exp_v);
      end
    end
  endtask

  task automatic test_stop();
    high_len = 5; low_len = 5; pulse_num = 4; start = 1;
    for (int c = 1; c <= 6; c++) begin
      advance();
      start = (c == 2); stop = (c == 3); pulse_num = (c == 2) ? 1 : 4;
      total++;
      if ({wave_out, busy, done} !== {c <= 3, c <= 3, c == 4} || act_v !== exp_v) begin
        bad++; $display("FAIL stop c=%0d got=%b exp=%b", c, act_v, exp_v);
      end
    end
    start = 0; stop = 0;
  endtask

  task automatic test_stop_start_idle();
    high_len = 2; low_len = 2; pulse_num = 1; start = 1; stop = 1;
    for (int c = 1; c <= 3; c++) begin
      advance(); start = 0; stop = 0;
      total++;
      if (act_v !== 5'b0) begin bad++; $display("FAIL stop_start c=%0d got=%b exp=%b", c, act_v, 5'b0); end
    end
  endtask

  task automatic test_reset_mid();
    high_len = 10; low_len = 3; pulse_num = 2; start = 1;
    for (int c = 1; c <= 7; c++) begin
      advance(); start = 0;
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL rst_mid_pre c=%0d got=%b exp=%b", c, act_v, exp_v); end
    end
    sys_rst = 1'b1; #1;
    total++;
    if (wave_out !== 1'b0) begin bad++; $display("FAIL rst_mid_wave got=%b exp=0", wave_out); end
    total++;
    if ({busy, done, wave_fall} !== 3'b0) begin bad++; $display("FAIL rst_mid_flags got=%b exp=000", {busy, done, wave_fall}); end
    model_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      advance();
      total++;
      if (act_v !== 5'b0) begin bad++; $display("FAIL rst_mid_idle got=%b exp=%b", act_v, 5'b0); end
    end
    high_len = 2; low_len = 1; pulse_num = 1; start = 1;
    for (int c = 1; c <= 5; c++) begin
      advance(); start = 0;
      total++;
      if (act_v !== exp_v || done !== (c == 4)) begin
        bad++; $display("FAIL rst_mid_restart c=%0d got=%b exp=%b", c, act_v, exp_v);
      end
    end
  endtask

  task automatic test_max_counts();
    high_len = '1; low_len = '1; pulse_num = '1; start = 1;
    for (int c = 1; c <= 213; c++) begin
      advance(); start = 0;
      high_len = CW'($urandom); low_len = CW'($urandom); pulse_num = NW'($urandom);
      total++;
      if (act_v !== exp_v || done !== (c == 211)) begin
        bad++; $display("FAIL max c=%0d got=%b exp=%b", c, act_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 29) == 0);
      high_len = CW'($urandom_range(0, 4));
      low_len = CW'($urandom_range(0, 4));
      pulse_num = NW'($urandom_range(0, 3));
      advance();
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL random c=%0d got=%b exp=%b", c, act_v, exp_v); end
    end
    start = 0; stop = 0;
    for (int c = 0; c < 80; c++) advance();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_pulses();
    test_zero_lengths();
    test_stop();
    test_stop_start_idle();
    test_reset_mid();
    test_max_counts();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_pulse_gen.md
EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of the phase-length inputs and internal phase counter.
REQ-002 Parameter NUM_W, default 8, width of the pulse-count input and internal pulse counter.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a pulse train; sampled only in IDLE.
REQ-006 stop  input  1  abort request; sampled every cycle.
REQ-007 high_len  input  CNT_W  high-phase length in cycles; latched on accepted start.
REQ-008 low_len  input  CNT_W  low-phase length in cycles; latched on accepted start.
REQ-009 pulse_num  input  NUM_W  number of pulses in the train; latched on accepted start.
REQ-010 wave_out  output  1  generated waveform, registered.
REQ-011 busy  output  1  high while a train is in progress (HIGH or LOW state).
REQ-012 done  output  1  one-cycle strobe at train completion or abort.
REQ-013 wave_rise  output  1  one-cycle strobe coincident with each 0->1 transition of wave_out.
REQ-014 wave_fall  output  1  one-cycle strobe coincident with each 1->0 transition of wave_out.

Function
REQ-015 The FSM SHALL have states IDLE, HIGH, LOW and FIN; HIGH drives wave_out=1, all other states drive wave_out=0.
REQ-016 start=1 in IDLE with stop=0 and pulse_num!=0 at edge T SHALL latch all lengths and enter HIGH, giving wave_out=1 and busy=1 from cycle T+1.
REQ-017 start in IDLE with pulse_num=0 SHALL go directly to FIN: done=1 at T+1, no pulse, busy stays 0.
REQ-018 high_len or low_len of 0 SHALL be treated as 1.
REQ-019 HIGH SHALL last exactly H cycles and LOW exactly L cycles (H, L = latched effective lengths); HIGH always precedes LOW.
REQ-020 At the end of LOW the pulse counter SHALL increment; if it is below N the FSM SHALL re-enter HIGH, otherwise it SHALL enter FIN.
REQ-021 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE; first pulse starts at T+1, done is asserted at T+N*(H+L)+1.
REQ-022 start while not in IDLE SHALL be ignored; inputs changing during a train SHALL NOT affect it.
REQ-023 stop=1 in HIGH or LOW SHALL enter FIN on the next edge (wave_out=0, done=1); stop and start together in IDLE: stop wins, nothing starts.
REQ-024 Phase and pulse counters SHALL saturate at their terminal counts; no wrap-around within a train.

Reset
REQ-025 While sys_rst=1, the FSM SHALL be IDLE and wave_out, busy, done, wave_rise, wave_fall and all counters SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-train SHALL drop wave_out to 0 immediately, without asserting done or wave_fall; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-027 Macro EDGE_PULSE_GEN_MARK_EN defined: wave_rise/wave_fall SHALL be generated per REQ-013/014, including the fall caused by stop.
REQ-028 Macro EDGE_PULSE_GEN_MARK_EN undefined: wave_rise and wave_fall SHALL remain ports tied to constant 0, with no associated logic.

Verification
REQ-029 H=3, L=2, N=2 start at cycle 0 -> wave_out high cycles 1-3 and 6-8, low cycles 4-5 and 9-10, done=1 at cycle 11 only, busy=1 cycles 1-10.
REQ-030 pulse_num=0 start at 0 -> done=1 at cycle 1, wave_out and busy stay 0.
REQ-031 H=0, L=0, N=3 -> wave_out alternates 1,0 for 6 cycles from cycle 1, done at cycle 7.
REQ-032 H=5, L=5, N=4; stop at cycle 3 -> wave_out=0 and done=1 at cycle 4, IDLE at cycle 5; start at cycle 2 ignored.
REQ-033 sys_rst pulsed at cycle 7 of an H=10 train -> wave_out=0 same cycle, no done; new start after release runs normally.
REQ-034 With EDGE_PULSE_GEN_MARK_EN, H=3, L=2, N=2 -> wave_rise at cycles 1 and 6, wave_fall at 4 and 9; without the macro both are always 0.
